// File: rtl/computer_pkg.sv
// Shared definitions for the SAP control path: opcode encodings, microstep
// constants and the packed control word that the microcode ROM produces.
package computer_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'b0000,
    OP_LDA = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_STA = 4'b0100,
    OP_LDI = 4'b0101,
    OP_JMP = 4'b0110,
    OP_JC  = 4'b0111,
    OP_JZ  = 4'b1000,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } opcode_e;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  // hlt is internal: it tells the sequencer to set its halted bit.
  typedef struct packed {
    logic oe_pc;
    logic oe_ram;
    logic oe_ir;
    logic oe_a;
    logic oe_alu;
    logic load_mar;
    logic load_ir;
    logic load_a;
    logic load_b;
    logic load_out;
    logic ram_we;
    logic pc_enable;
    logic pc_load;
    logic alu_sub;
    logic flag_enable;
    logic hlt;
  } ctrl_word_t;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode decode: (opcode, microstep, flags) -> control word
// plus last_step, which marks the final step of the current instruction.
// Steps with no microcode (beyond an instruction's end, or values above T4)
// decode to an all-zero word with last_step low.
// Ports: opcode, step, flag_carry, flag_zero in; ctrl, last_step out.
// Optional macro COND_JUMP_EN enables JC/JZ; otherwise they decode as NOP and
// the flag inputs are unused.
module microcode_rom
  import computer_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [STEP_W-1:0]   step,
  input  logic                flag_carry,
  input  logic                flag_zero,
  output ctrl_word_t          ctrl,
  output logic                last_step
);

  logic is_t2, is_t3, is_t4;
  assign is_t2 = (step == STEP_W'(T2));
  assign is_t3 = (step == STEP_W'(T3));
  assign is_t4 = (step == STEP_W'(T4));

`ifndef COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = flag_carry ^ flag_zero;
`endif

  always_comb begin
    ctrl      = '0;
    last_step = 1'b0;
    if (step == STEP_W'(T0)) begin
      ctrl.oe_pc    = 1'b1;
      ctrl.load_mar = 1'b1;
    end else if (step == STEP_W'(T1)) begin
      ctrl.oe_ram    = 1'b1;
      ctrl.load_ir   = 1'b1;
      ctrl.pc_enable = 1'b1;
    end else begin
      case (opcode)
        OPCODE_W'(OP_LDA): begin
          if (is_t2) begin
            ctrl.oe_ir    = 1'b1;
            ctrl.load_mar = 1'b1;
          end else if (is_t3) begin
            ctrl.oe_ram = 1'b1;
            ctrl.load_a = 1'b1;
            last_step   = 1'b1;
          end
        end
        OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
          if (is_t2) begin
            ctrl.oe_ir    = 1'b1;
            ctrl.load_mar = 1'b1;
          end else if (is_t3) begin
            ctrl.oe_ram = 1'b1;
            ctrl.load_b = 1'b1;
          end else if (is_t4) begin
            ctrl.oe_alu      = 1'b1;
            ctrl.load_a      = 1'b1;
            ctrl.flag_enable = 1'b1;
            ctrl.alu_sub     = (opcode == OPCODE_W'(OP_SUB));
            last_step        = 1'b1;
          end
        end
        OPCODE_W'(OP_STA): begin
          if (is_t2) begin
            ctrl.oe_ir    = 1'b1;
            ctrl.load_mar = 1'b1;
          end else if (is_t3) begin
            ctrl.oe_a   = 1'b1;
            ctrl.ram_we = 1'b1;
            last_step   = 1'b1;
          end
        end
        OPCODE_W'(OP_LDI): begin
          if (is_t2) begin
            ctrl.oe_ir  = 1'b1;
            ctrl.load_a = 1'b1;
            last_step   = 1'b1;
          end
        end
        OPCODE_W'(OP_JMP): begin
          if (is_t2) begin
            ctrl.oe_ir   = 1'b1;
            ctrl.pc_load = 1'b1;
            last_step    = 1'b1;
          end
        end
`ifdef COND_JUMP_EN
        // A not-taken jump still ends at T2, acting as a 3-cycle NOP.
        OPCODE_W'(OP_JC): begin
          if (is_t2) begin
            ctrl.oe_ir   = flag_carry;
            ctrl.pc_load = flag_carry;
            last_step    = 1'b1;
          end
        end
        OPCODE_W'(OP_JZ): begin
          if (is_t2) begin
            ctrl.oe_ir   = flag_zero;
            ctrl.pc_load = flag_zero;
            last_step    = 1'b1;
          end
        end
`endif
        OPCODE_W'(OP_OUT): begin
          if (is_t2) begin
            ctrl.oe_a     = 1'b1;
            ctrl.load_out = 1'b1;
            last_step     = 1'b1;
          end
        end
        OPCODE_W'(OP_HLT): begin
          if (is_t2) begin
            ctrl.hlt  = 1'b1;
            last_step = 1'b1;
          end
        end
        default: begin
          if (is_t2) last_step = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/microcode_sequencer.sv
// SAP control unit: microstep counter plus sticky halted bit; all datapath
// strobes come combinationally from microcode_rom and are forced low during
// reset or while halted.
// Ports: clk, reset (sync, active-high), opcode, flag_carry, flag_zero in;
// bus enables oe_*, load strobes load_*, ram_we, pc_enable, pc_load, alu_sub,
// flag_enable, microstep (debug), halted, instr_done out.
// Optional macro COND_JUMP_EN (handled in microcode_rom) adds JC/JZ.
module microcode_sequencer
  import computer_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int STEP_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flag_carry,
  input  logic                flag_zero,
  output logic                oe_pc,
  output logic                oe_ram,
  output logic                oe_ir,
  output logic                oe_a,
  output logic                oe_alu,
  output logic                load_mar,
  output logic                load_ir,
  output logic                load_a,
  output logic                load_b,
  output logic                load_out,
  output logic                ram_we,
  output logic                pc_enable,
  output logic                pc_load,
  output logic                alu_sub,
  output logic                flag_enable,
  output logic [STEP_W-1:0]   microstep,
  output logic                halted,
  output logic                instr_done
);

  logic [STEP_W-1:0] step_q, step_d;
  logic              halted_q, halted_d;
  ctrl_word_t        rom_ctrl, ctrl;
  logic              rom_last;
  logic              active;

  microcode_rom #(
    .OPCODE_W(OPCODE_W),
    .STEP_W  (STEP_W)
  ) u_rom (
    .opcode    (opcode),
    .step      (step_q),
    .flag_carry(flag_carry),
    .flag_zero (flag_zero),
    .ctrl      (rom_ctrl),
    .last_step (rom_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      step_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    active     = ~reset & ~halted_q;
    ctrl       = active ? rom_ctrl : '0;
    instr_done = active & rom_last;
    halted_d   = halted_q | (active & rom_ctrl.hlt);
    // Any step at or past T4 wraps, so stray values recover to T0 in one cycle.
    if (halted_q || rom_last || step_q >= STEP_W'(T4))
      step_d = '0;
    else
      step_d = step_q + STEP_W'(1);
  end

  assign oe_pc       = ctrl.oe_pc;
  assign oe_ram      = ctrl.oe_ram;
  assign oe_ir       = ctrl.oe_ir;
  assign oe_a        = ctrl.oe_a;
  assign oe_alu      = ctrl.oe_alu;
  assign load_mar    = ctrl.load_mar;
  assign load_ir     = ctrl.load_ir;
  assign load_a      = ctrl.load_a;
  assign load_b      = ctrl.load_b;
  assign load_out    = ctrl.load_out;
  assign ram_we      = ctrl.ram_we;
  assign pc_enable   = ctrl.pc_enable;
  assign pc_load     = ctrl.pc_load;
  assign alu_sub     = ctrl.alu_sub;
  assign flag_enable = ctrl.flag_enable;
  assign microstep   = step_q;
  assign halted      = halted_q;

endmodule
